instruction_encoder: RTL and testbench

//  Inverse of the instruction-field decoder: packs decoded ARM fields (cond, 5-bit internal opcode,

---
 rtl/arm_isa_pkg.sv | 52 +++++
 rtl/instruction_encoder_if.sv | 54 +++++
 rtl/instr_field_pack.sv | 35 +++
 rtl/instruction_encoder.sv | 125 ++++++++++++
 tb/tb_instruction_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_isa_pkg.sv
// Shared ARM encoding constants and the decoded-field bundle used by the instruction encoder.
// Internal opcode space: 0xxxx data processing, 10000 single data transfer, 10001 branch.
package arm_isa_pkg;

    localparam logic [4:0] OP_SDT     = 5'b10000;
    localparam logic [4:0] OP_BR      = 5'b10001;
    localparam logic [4:0] OP_INVALID = 5'b11111;

    localparam logic [1:0] FMT_DP  = 2'b00;
    localparam logic [1:0] FMT_SDT = 2'b01;
    localparam logic [2:0] FMT_BR  = 3'b101;

    // MOV r0,r0 with cond=AL
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE1A00000;

    typedef enum logic [1:0] {
        KIND_DP  = 2'd0,
        KIND_SDT = 2'd1,
        KIND_BR  = 2'd2,
        KIND_BAD = 2'd3
    } instr_kind_e;

    typedef struct packed {
        logic [3:0]  cond;
        logic [4:0]  opcode;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic        s_bit;
        logic        i_bit;
        logic [11:0] shv;
        logic        p_bit;
        logic        u_bit;
        logic        b_bit;
        logic        w_bit;
        logic        l_bit;
        logic        link_bit;
        logic [23:0] br_imm;
    } fields_t;

    function automatic instr_kind_e classify(input logic [4:0] op);
        if (!op[4])
            return KIND_DP;
        else if (op == OP_SDT)
            return KIND_SDT;
        else if (op == OP_BR)
            return KIND_BR;
        else
            return KIND_BAD;
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-bundle input stream, encoded-word output stream and address control for instruction_encoder.
// The encoder is the slave; the loader/bench driving fields and consuming words is the master.
interface instruction_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              flush;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_init;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cond;
    logic [4:0]        opcode;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [3:0]        rm;
    logic              CPSRwrite;
    logic              immediateOperand;
    logic [11:0]       shifterVals;
    logic              prePostAddOffset;
    logic              upDownOffset;
    logic              byteOrWord;
    logic              writeBack;
    logic              loadStore;
    logic              linkBit;
    logic [23:0]       branchImmediate;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              out_invalid;

    modport slave (
        input  flush, addr_load, addr_init,
        input  in_valid, cond, opcode, rn, rd, rm, CPSRwrite, immediateOperand,
        input  shifterVals, prePostAddOffset, upDownOffset, byteOrWord, writeBack,
        input  loadStore, linkBit, branchImmediate,
        output in_ready,
        output out_valid, out_word, out_addr, out_invalid,
        input  out_ready
    );

    modport master (
        output flush, addr_load, addr_init,
        output in_valid, cond, opcode, rn, rd, rm, CPSRwrite, immediateOperand,
        output shifterVals, prePostAddOffset, upDownOffset, byteOrWord, writeBack,
        output loadStore, linkBit, branchImmediate,
        input  in_ready,
        input  out_valid, out_word, out_addr, out_invalid,
        output out_ready
    );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: one decoded field bundle -> 32-bit ARM word plus an invalid-opcode flag.
module instr_field_pack
    import arm_isa_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  fields_t     f,
    output logic [31:0] word,
    output logic        invalid
);

    logic [3:0] dp_op2lo;
    logic [3:0] sdt_op2lo;

    // The I bit selects the low nibble in opposite senses for DP and SDT.
    assign dp_op2lo  = f.i_bit ? f.shv[3:0] : f.rm;
    assign sdt_op2lo = f.i_bit ? f.rm : f.shv[3:0];

    always_comb begin
        word    = NOP_WORD;
        invalid = 1'b0;
        case (classify(f.opcode))
            KIND_DP:  word = {f.cond, FMT_DP, f.i_bit, f.opcode[3:0], f.s_bit,
                              f.rn, f.rd, f.shv[11:4], dp_op2lo};
            KIND_SDT: word = {f.cond, FMT_SDT, f.i_bit, f.p_bit, f.u_bit, f.b_bit,
                              f.w_bit, f.l_bit, f.rn, f.rd, f.shv[11:4], sdt_op2lo};
            KIND_BR:  word = {f.cond, FMT_BR, f.link_bit, f.br_imm};
            default: begin
                word    = NOP_WORD;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready pipeline that packs decoded ARM fields into instruction words and tags
// each with a wrapping instruction-memory word address.
module instruction_encoder
    import arm_isa_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              s1_valid_q, s1_valid_d;
    fields_t           s1_fields_q, s1_fields_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_word_q, s2_word_d;
    logic              s2_invalid_q, s2_invalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    fields_t     in_fields;
    logic [31:0] pack_word;
    logic        pack_invalid;
    logic        s2_free;
    logic        in_ready;
    logic        in_fire;
    logic        s1_adv;
    logic        out_fire;

    always_comb begin
        in_fields          = '0;
        in_fields.cond     = bus.cond;
        in_fields.opcode   = bus.opcode;
        in_fields.rn       = bus.rn;
        in_fields.rd       = bus.rd;
        in_fields.rm       = bus.rm;
        in_fields.s_bit    = bus.CPSRwrite;
        in_fields.i_bit    = bus.immediateOperand;
        in_fields.shv      = bus.shifterVals;
        in_fields.p_bit    = bus.prePostAddOffset;
        in_fields.u_bit    = bus.upDownOffset;
        in_fields.b_bit    = bus.byteOrWord;
        in_fields.w_bit    = bus.writeBack;
        in_fields.l_bit    = bus.loadStore;
        in_fields.link_bit = bus.linkBit;
        in_fields.br_imm   = bus.branchImmediate;
    end

    instr_field_pack #(
        .NOP_WORD (NOP_WORD)
    ) u_pack (
        .f       (s1_fields_q),
        .word    (pack_word),
        .invalid (pack_invalid)
    );

    // Flush and reset both block every transfer, so no handshake is ever counted in those cycles.
    assign s2_free  = !s2_valid_q || bus.out_ready;
    assign in_ready = reset && !bus.flush && (!s1_valid_q || s2_free);
    assign in_fire  = bus.in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_free && !bus.flush;
    assign out_fire = s2_valid_q && bus.out_ready && !bus.flush;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_fields_d  = s1_fields_q;
        s2_valid_d   = s2_valid_q;
        s2_word_d    = s2_word_q;
        s2_invalid_d = s2_invalid_q;

        if (bus.flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_adv)
                s1_valid_d = 1'b0;
            if (in_fire) begin
                s1_valid_d  = 1'b1;
                s1_fields_d = in_fields;
            end
            if (s2_free)
                s2_valid_d = s1_valid_q;
            if (s1_adv) begin
                s2_word_d    = pack_word;
                s2_invalid_d = pack_invalid;
            end
        end
    end

    // A load wins over a same-cycle increment; the loaded value tags the next word out.
    always_comb begin
        addr_d = addr_q;
        if (bus.addr_load)
            addr_d = bus.addr_init;
        else if (out_fire)
            addr_d = addr_q + ADDR_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_fields_q  <= '0;
            s2_valid_q   <= 1'b0;
            s2_word_q    <= '0;
            s2_invalid_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_fields_q  <= s1_fields_d;
            s2_valid_q   <= s2_valid_d;
            s2_word_q    <= s2_word_d;
            s2_invalid_q <= s2_invalid_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_word    = s2_word_q;
    assign bus.out_addr    = addr_q;
    assign bus.out_invalid = s2_invalid_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder: stimulus pushes hand-computed words into a
// scoreboard queue, an independent monitor pops and compares on every output handshake.
module tb_instruction_encoder;
    import arm_isa_pkg::*;

    localparam int ADDR_W = 6;

    typedef struct {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
        logic              inv;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    function automatic fields_t dp(input logic [3:0] cond, input logic [3:0] alu, input logic i,
                                   input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                   input logic [3:0] rm, input logic [11:0] shv);
        fields_t f = '0;
        f.cond = cond; f.opcode = {1'b0, alu}; f.i_bit = i; f.s_bit = s;
        f.rn = rn; f.rd = rd; f.rm = rm; f.shv = shv;
        return f;
    endfunction

    function automatic fields_t sdt(input logic [3:0] cond, input logic i, input logic p,
                                    input logic u, input logic b, input logic w, input logic l,
                                    input logic [3:0] rn, input logic [3:0] rd,
                                    input logic [3:0] rm, input logic [11:0] shv);
        fields_t f = '0;
        f.cond = cond; f.opcode = OP_SDT; f.i_bit = i;
        f.p_bit = p; f.u_bit = u; f.b_bit = b; f.w_bit = w; f.l_bit = l;
        f.rn = rn; f.rd = rd; f.rm = rm; f.shv = shv;
        return f;
    endfunction

    function automatic fields_t br(input logic [3:0] cond, input logic link, input logic [23:0] imm);
        fields_t f = '0;
        f.cond = cond; f.opcode = OP_BR; f.link_bit = link; f.br_imm = imm;
        return f;
    endfunction

    function automatic fields_t raw(input logic [3:0] cond, input logic [4:0] op);
        fields_t f = '0;
        f.cond = cond; f.opcode = op; f.rn = 4'h5; f.rd = 4'h6; f.shv = 12'hABC;
        return f;
    endfunction

    task automatic drive(input fields_t f);
        bus.cond             = f.cond;
        bus.opcode           = f.opcode;
        bus.rn               = f.rn;
        bus.rd               = f.rd;
        bus.rm               = f.rm;
        bus.CPSRwrite        = f.s_bit;
        bus.immediateOperand = f.i_bit;
        bus.shifterVals      = f.shv;
        bus.prePostAddOffset = f.p_bit;
        bus.upDownOffset     = f.u_bit;
        bus.byteOrWord       = f.b_bit;
        bus.writeBack        = f.w_bit;
        bus.loadStore        = f.l_bit;
        bus.linkBit          = f.link_bit;
        bus.branchImmediate  = f.br_imm;
    endtask

    task automatic push_exp(input logic [31:0] w, input logic inv, input int a);
        exp_t e;
        e.word = w;
        e.addr = ADDR_W'(a);
        e.inv  = inv;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1; presents one bundle for one cycle.
    task automatic offer(input fields_t f, input logic [31:0] w, input logic inv, input int a,
                         output bit acc);
        drive(f);
        bus.in_valid = 1'b1;
        @(negedge clk);
        acc = bus.in_ready;
        if (acc) begin
            push_exp(w, inv, a);
            $display("IN  op=%b expect word=%h addr=%0d inv=%0d", f.opcode, w, a, inv);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input fields_t f, input logic [31:0] w, input logic inv, input int a,
                        output int tries);
        bit acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            offer(f, w, inv, a, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted word=%h", w);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && !bus.flush && bus.out_valid && bus.out_ready) begin
                $display("OUT word=%h addr=%0d inv=%0d", bus.out_word, bus.out_addr, bus.out_invalid);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%h expected=none", bus.out_word);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", bus.out_word, e.word);
                    chk("out_addr", 32'(bus.out_addr), 32'(e.addr));
                    chk("out_invalid", 32'(bus.out_invalid), 32'(e.inv));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, t3, idx;
        bit seen;
        logic [31:0] held_w;
        logic [ADDR_W-1:0] held_a;
        fields_t bp_f[4];
        logic [31:0] bp_w[4];

        drive('0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.addr_load = 1'b0;
        bus.addr_init = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_word", bus.out_word, 0);
        chk("rst_out_invalid", 32'(bus.out_invalid), 0);
        chk("rst_out_addr", 32'(bus.out_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single DP word and its two-cycle latency
        bus.out_ready = 1'b1;
        send(dp(4'hE, 4'b0100, 1'b1, 1'b0, 4'd13, 4'd11, 4'd0, 12'h004), 32'hE28DB004, 1'b0, 0, t);
        @(negedge clk);
        chk("lat_early_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_due_valid", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back SDT, branch, MOV, then register-operand DP and SDT
        send(sdt(4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 4'd0, 4'd0, 12'h014),
             32'hE59F0014, 1'b0, 1, t1);
        send(br(4'hE, 1'b1, 24'hFFFFFE), 32'hEBFFFFFE, 1'b0, 2, t2);
        send(dp(4'hE, 4'b1101, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 12'h000), 32'hE3A03000, 1'b0, 3, t3);
        chk("b2b_no_stall", t1 + t2 + t3, 3);
        send(dp(4'hE, 4'b0100, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 12'h0A5), 32'hE09120A3, 1'b0, 4, t);
        send(sdt(4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 4'd7, 12'h100),
             32'h07625107, 1'b0, 5, t);
        drain();

        // Invalid opcodes still consume addresses
        send(raw(4'h3, 5'b10110), 32'hE1A00000, 1'b1, 6, t);
        send(raw(4'hE, OP_INVALID), 32'hE1A00000, 1'b1, 7, t);
        send(dp(4'hE, 4'b1101, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 12'h000), 32'hE3A03000, 1'b0, 8, t);
        drain();

        // Backpressure: 4 bundles offered over 5 stalled cycles
        bp_f[0] = sdt(4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 4'd0, 4'd0, 12'h014);
        bp_w[0] = 32'hE59F0014;
        bp_f[1] = br(4'hE, 1'b1, 24'hFFFFFE);
        bp_w[1] = 32'hEBFFFFFE;
        bp_f[2] = dp(4'hE, 4'b1101, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 12'h000);
        bp_w[2] = 32'hE3A03000;
        bp_f[3] = dp(4'hE, 4'b0100, 1'b1, 1'b0, 4'd13, 4'd11, 4'd0, 12'h004);
        bp_w[3] = 32'hE28DB004;
        bus.out_ready = 1'b0;
        idx  = 0;
        seen = 1'b0;
        held_w = '0;
        held_a = '0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) begin
                drive(bp_f[idx]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                push_exp(bp_w[idx], 1'b0, 9 + idx);
                $display("IN  bp bundle=%0d expect word=%h addr=%0d", idx, bp_w[idx], 9 + idx);
                idx++;
            end
            if (bus.out_valid) begin
                if (!seen) begin
                    held_w = bus.out_word;
                    held_a = bus.out_addr;
                    seen   = 1'b1;
                end else begin
                    chk("bp_hold_word", bus.out_word, held_w);
                    chk("bp_hold_addr", 32'(bus.out_addr), 32'(held_a));
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", idx, 2);
        chk("bp_out_seen", 32'(seen), 1);
        chk("bp_head_word", held_w, bp_w[0]);
        bus.out_ready = 1'b1;
        for (int i = 2; i < 4; i++)
            send(bp_f[i], bp_w[i], 1'b0, 9 + i, t);
        drain();

        // Address load to all-ones, then wrap to zero
        bus.addr_load = 1'b1;
        bus.addr_init = 6'h3F;
        @(posedge clk);
        #1;
        bus.addr_load = 1'b0;
        send(br(4'hA, 1'b0, 24'h000010), 32'hAA000010, 1'b0, 63, t);
        send(dp(4'hE, 4'b1101, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 12'h000), 32'hE3A03000, 1'b0, 0, t);
        drain();

        // Flush with both stages full
        bus.out_ready = 1'b0;
        send(br(4'hE, 1'b0, 24'h000001), 32'hEA000001, 1'b0, 1, t);
        send(br(4'hE, 1'b0, 24'h000002), 32'hEA000002, 1'b0, 2, t);
        @(negedge clk);
        chk("flush_pre_valid", 32'(bus.out_valid), 1);
        chk("flush_pre_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_addr_kept", 32'(bus.out_addr), 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(br(4'hE, 1'b1, 24'h000003), 32'hEB000003, 1'b0, 1, t);
        drain();

        // Reset mid-stream
        bus.out_ready = 1'b0;
        send(br(4'hE, 1'b0, 24'h000004), 32'hEA000004, 1'b0, 2, t);
        send(br(4'hE, 1'b0, 24'h000005), 32'hEA000005, 1'b0, 3, t);
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst2_out_valid", 32'(bus.out_valid), 0);
        chk("rst2_out_addr", 32'(bus.out_addr), 0);
        chk("rst2_out_word", bus.out_word, 0);
        chk("rst2_out_invalid", 32'(bus.out_invalid), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(sdt(4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 4'd0, 4'd0, 12'h014),
             32'hE59F0014, 1'b0, 0, t);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
